lifo_stack_p: RTL and testbench

Parametrised LIFO stack, the next generation of the fixed 8-bit stack. It adds configurable width and depth, a registered top-of-stack output, and an occupancy count. It also supports simultaneous push+pop (replace top), a synchronous clear, an almost-full threshold, and sticky overflow/underflow error flags. It is a generic buffering primitive for datapath and control blocks in the week-8 designs.

---
 rtl/lifo_stack_p.sv | 122 ++++++++++++
 tb/tb_lifo_stack_p.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lifo_stack_p.sv
// lifo_stack_p -- parametrised LIFO stack with a registered top-of-stack output.
//
// Parameters:
//   WIDTH    data word width (>=1)
//   DEPTH    number of entries (>=2, any value)
//   AF_LEVEL occupancy at or above which almost_full asserts (1..DEPTH)
//   CW       count width, $clog2(DEPTH+1)
//
// Ports:
//   clk         rising-edge clock
//   resetb      asynchronous active-low reset
//   datain      word to push
//   push, pop   requests sampled on the rising edge; both together replace the top
//   clear       synchronous flush, overrides push/pop
//   dataout     registered top-of-stack word, 0 when empty
//   count       stored entries, 0..DEPTH
//   full, empty, almost_full  decoded from count
//   overflow    sticky: push dropped while full
//   underflow   sticky: pop ignored while empty
module lifo_stack_p #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [WIDTH-1:0] datain,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] dataout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVF,
    OP_UNF
  } op_e;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] top;
  op_e              op;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    rd_idx;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign dataout     = top;

  // Single decoded operation per edge from the pre-edge count.
  // push+pop on an empty stack degenerates to a plain push (no underflow).
  always_comb begin
    op = OP_HOLD;
    if (clear)              op = OP_CLEAR;
    else if (push && pop)   op = empty ? OP_PUSH : OP_REPLACE;
    else if (push)          op = full  ? OP_OVF  : OP_PUSH;
    else if (pop)           op = empty ? OP_UNF  : OP_POP;
  end

  // Indices are computed at count width; the value is always < DEPTH
  // when used, so narrowing to the array address is lossless.
  always_comb begin
    wr_idx  = (op == OP_REPLACE) ? (count - CW'(1)) : count;
    rd_idx  = count - CW'(2);
    wr_addr = AW'(wr_idx);
    rd_addr = AW'(rd_idx);
  end

  // Storage is intentionally not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (op == OP_PUSH || op == OP_REPLACE)
      mem[wr_addr] <= datain;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (op)
        OP_CLEAR: begin
          count     <= '0;
          top       <= '0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        OP_PUSH: begin
          count <= count + CW'(1);
          top   <= datain;
        end
        OP_POP: begin
          count <= count - CW'(1);
          // New top is the entry below the popped one, if any.
          top   <= (count >= CW'(2)) ? mem[rd_addr] : '0;
        end
        OP_REPLACE: top <= datain;
        OP_OVF:     overflow  <= 1'b1;
        OP_UNF:     underflow <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack_p.sv
// tb_lifo_stack_p -- directed plus randomized check of lifo_stack_p against a
// queue-based reference model (WIDTH=8, DEPTH=8, AF_LEVEL=7).
module tb_lifo_stack_p;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 7;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             resetb;
  logic [WIDTH-1:0] datain;
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] dataout;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  lifo_stack_p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .resetb(resetb), .datain(datain), .push(push), .pop(pop),
    .clear(clear), .dataout(dataout), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of the stack.
  logic [WIDTH-1:0] q[$];
  logic             m_ovf;
  logic             m_unf;
  int               vectors;
  int               miscompares;

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update(input logic p, input logic o, input logic c,
                              input logic [WIDTH-1:0] d);
    if (c) model_reset();
    else if (p && o && q.size() > 0) q[q.size()-1] = d;
    else if (p) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end else if (o) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, exp);
    end
  endtask

  task automatic check(input string tag);
    int n;
    n = q.size();
    cmp(tag, "count",       32'(count),       32'(n));
    cmp(tag, "dataout",     32'(dataout),     (n > 0) ? 32'(q[n-1]) : 32'd0);
    cmp(tag, "full",        32'(full),        32'(n == DEPTH));
    cmp(tag, "empty",       32'(empty),       32'(n == 0));
    cmp(tag, "almost_full", 32'(almost_full), 32'(n >= AF));
    cmp(tag, "overflow",    32'(overflow),    32'(m_ovf));
    cmp(tag, "underflow",   32'(underflow),   32'(m_unf));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at
  // the next falling edge.
  task automatic step(input logic p, input logic o, input logic c,
                      input logic [WIDTH-1:0] d, input string tag);
    push = p; pop = o; clear = c; datain = d;
    @(posedge clk);
    model_update(p, o, c, d);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    check(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    resetb = 1'b0;
    push = 1'b0; pop = 1'b0; clear = 1'b0; datain = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset");
    resetb = 1'b1;

    // Fill 10..80, then one overflowing push of 90, then idle.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i * 10), "fill");
    step(1'b1, 1'b0, 1'b0, 8'd90, "overflow");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, "ovf_hold");

    // Drain 8, then one underflowing pop.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'd0, "drain");
    step(1'b0, 1'b1, 1'b0, 8'd0, "underflow");

    // Replace.
    step(1'b0, 1'b0, 1'b1, 8'd0, "clear1");
    step(1'b1, 1'b0, 1'b0, 8'd5, "rep_push5");
    step(1'b1, 1'b0, 1'b0, 8'd6, "rep_push6");
    step(1'b1, 1'b1, 1'b0, 8'd7, "replace7");
    step(1'b0, 1'b1, 1'b0, 8'd0, "rep_pop");
    step(1'b1, 1'b1, 1'b0, 8'd0, "rep_last");
    step(1'b0, 1'b1, 1'b0, 8'd0, "pop_to_empty");
    step(1'b1, 1'b1, 1'b0, 8'd44, "pushpop_empty");

    // Clear priority with count=3 and overflow set.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(100 + i), "refill");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'd0, "to_three");
    step(1'b1, 1'b1, 1'b1, 8'hAA, "clear_prio");

    // Asynchronous reset between edges mid-fill.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(i + 1), "prefill");
    resetb = 1'b0;
    #2;
    model_reset();
    check("async_rst");
    #1 resetb = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'd33, "post_rst");

    // Randomized traffic: push-biased first half, pop-biased second half.
    for (int i = 0; i < 400; i++) begin
      logic p, o, c;
      c = ($urandom_range(0, 40) == 0);
      if (i < 200) begin
        p = ($urandom_range(0, 3) != 0);
        o = ($urandom_range(0, 2) == 0);
      end else begin
        p = ($urandom_range(0, 2) == 0);
        o = ($urandom_range(0, 3) != 0);
      end
      step(p, o, c, 8'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
